mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port OSECPU Memory (sync read, 1 access/cycle) between
//  two requesters: port 0 = instruction fetch, port 1 = data load/store.
//  Round-robin grant, pipelined reads, per-port read-data return with tags.
//  Sits between the OSECPU sequencer/datapath and the Memory instance.
// PARAMETERS
//  ADDR_W   16  memory address width (words)
//  DATA_W   32  memory data width
//  RD_LAT    1  cycles from accepted read to mem_rdata valid (1..4)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  reset       in   1       synchronous, ACTIVE-LOW (reset==0 resets)
//  p0_req      in   1       port0 access request (held until p0_gnt)
//  p0_we       in   1       port0 write enable (qualified by p0_req)
//  p0_addr     in   ADDR_W  port0 address
//  p0_wdata    in   DATA_W  port0 write data
//  p0_gnt      out  1       port0 request accepted this cycle (comb.)
//  p0_rvalid   out  1       port0 read data valid (registered)
//  p0_rdata    out  DATA_W  port0 read data
//  p1_*        --   --      same seven signals for port1
//  mem_addr    out  ADDR_W  to Memory
//  mem_wdata   out  DATA_W  to Memory
//  mem_we      out  1       to Memory
//  mem_rdata   in   DATA_W  from Memory, valid RD_LAT cycles after access
// BEHAVIOUR
//  - Reset (reset==0 at posedge): rr_ptr<=0 (port0 favoured), tag pipe
//    cleared; while reset==0: p*_gnt=0, mem_we=0, p*_rvalid=0, rdata=0.
//  - Grant (comb.): one req -> grant it; both req -> grant port rr_ptr.
//    At most one gnt per cycle. mem_addr/mem_wdata/mem_we follow the
//    granted port same cycle; no grant -> mem_we=0, mem_addr=0.
//  - rr_ptr update at posedge on grant: rr_ptr <= ~granted_port. No grant
//    -> hold. Continuous requester granted within 2 cycles (no starvation).
//  - Requester must hold req/we/addr/wdata stable until gnt; after gnt it
//    may issue next request the following cycle (back-to-back allowed).
//  - Write: completes at the gnt edge; no rvalid generated.
//  - Read: tag {valid,port} enters RD_LAT-deep shift pipe at gnt edge; when
//    tag exits, the tagged port's rvalid=1 for exactly 1 cycle with
//    rdata=mem_rdata (registered); other port rvalid=0, rdata holds.
//  - Throughput 1 access/cycle; reads return in issue order; rvalid latency
//    = RD_LAT+1 cycles after gnt cycle (RD_LAT=1 -> rvalid 2 edges later).
//  - Read-after-write same address, back-to-back: read returns new data
//    (Memory write-first is not required; arbiter guarantees write edge
//    precedes read edge).
//  - reset==0 mid-operation: in-flight read tags discarded, no rvalid is
//    emitted for them after reset releases.
//  - Address arithmetic none; addresses pass through unmodified, no wrap.
// STRUCTURE
//  - Package osecpu_mem_pkg: ADDR_W/DATA_W defaults, PORT_FETCH=0,
//    PORT_DATA=1, tag struct {valid, port}.
//  - Sub-module rd_tag_pipe: RD_LAT-stage shift register of tags with
//    synchronous active-low clear; arbiter top holds grant logic + rr_ptr.
// TESTING
//  1 Reset: hold reset=0 3 cycles with p0_req=p1_req=1 -> all gnt/rvalid/
//    mem_we =0; release -> first cycle p0_gnt=1.
//  2 Lone reads: p0 read addr 0x0005 (mem[5]=0x12340002) -> p0_gnt same
//    cycle, p0_rvalid 2 edges later, p0_rdata=0x12340002, p1_rvalid=0.
//  3 Contention: both req continuously 6 cycles -> gnt alternates
//    p0,p1,p0,p1,p0,p1; each read returned to correct port in order.
//  4 Write then read: p1 write 0x0010<-0xFFFFFFFC, next cycle p1 read
//    0x0010 -> p1_rdata=0xFFFFFFFC, no rvalid for the write.
//  5 Reset mid-flight: p0 read gnt, reset=0 next cycle for 1 cycle ->
//    no p0_rvalid ever for that read; rr_ptr back to port0.
//  6 RD_LAT=3 build: 4 back-to-back reads -> rvalid pulses 4 consecutive
//    cycles starting 4 edges after first gnt, data in issue order.

Source files
------------

// File: rtl/osecpu_mem_pkg.sv
// Shared types and defaults for the OSECPU memory-port arbiter.
// Port identities, the read-return tag and the round-robin grant decision.
package osecpu_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  // Returns {gnt1, gnt0}: a lone requester always wins, a tie goes to ptr.
  function automatic logic [1:0] rr_grant(input logic req0, input logic req1,
                                          input port_e ptr);
    logic [1:0] g;
    g = 2'b00;
    if (req0 && (!req1 || ptr == PORT_FETCH)) begin
      g = 2'b01;
    end else if (req1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus.
// slave = arbiter view, master = requesters plus the memory instance.
interface mem_port_arbiter_if
  import osecpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the memory read latency.
// A tag leaves the last stage in the same cycle its data appears on mem_rdata.
module rd_tag_pipe
  import osecpu_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic clr_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_p[i] <= '0;
      end
    end else begin
      stage_p[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign tag_out = stage_p[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sync-read memory port between instruction
// fetch (port 0) and data load/store (port 1), with tagged read-data return.
module mem_port_arbiter
  import osecpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  port_e             rr_ptr;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;
  tag_t              tag_in;
  tag_t              tag_out;
  logic              rvalid0_p1;
  logic              rvalid1_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;

  // Grant is combinational and suppressed for the whole time reset is low.
  assign {gnt1, gnt0} = reset ? rr_grant(bus.p0_req, bus.p1_req, rr_ptr) : 2'b00;

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    if (gnt0) begin
      addr_sel  = bus.p0_addr;
      wdata_sel = bus.p0_wdata;
      we_sel    = bus.p0_we;
    end else if (gnt1) begin
      addr_sel  = bus.p1_addr;
      wdata_sel = bus.p1_wdata;
      we_sel    = bus.p1_we;
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = we_sel;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
    tag_in.port  = gnt1 ? PORT_DATA : PORT_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= PORT_FETCH;
    end else if (gnt0) begin
      rr_ptr <= PORT_DATA;
    end else if (gnt1) begin
      rr_ptr <= PORT_FETCH;
    end
  end

  // p0: access issued, tag travels alongside the memory read latency
  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .clr_n   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // p1: returning data registered into the tagged port; the other port holds
  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      rvalid0_p1 <= tag_out.valid && (tag_out.port == PORT_FETCH);
      rvalid1_p1 <= tag_out.valid && (tag_out.port == PORT_DATA);
      if (tag_out.valid && (tag_out.port == PORT_FETCH)) begin
        rdata0_p1 <= bus.mem_rdata;
      end
      if (tag_out.valid && (tag_out.port == PORT_DATA)) begin
        rdata1_p1 <= bus.mem_rdata;
      end
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = rvalid0_p1;
  assign bus.p1_rvalid = rvalid1_p1;
  assign bus.p0_rdata  = rdata0_p1;
  assign bus.p1_rdata  = rdata1_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 and RD_LAT=3 instances, each with a
// behavioural sync-read memory, a table of grant vectors and a read scoreboard.
module tb_mem_port_arbiter;
  import osecpu_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   npass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'h12340002;
    return 32'hC0DE0000 | a;
  endfunction

  // behavioural memories: write at the edge, read data RD_LAT cycles later
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = rd3[2];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
    end else begin
      if (b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
      if (b3.mem_we) mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
    end
    rd1    <= mem1[b1.mem_addr[7:0]];
    rd3[0] <= mem3[b3.mem_addr[7:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // scoreboard: expected read data and the cycle its rvalid must appear
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q3[$];
  logic [31:0] shadow1 [int];

  function automatic logic [31:0] sh_rd(input int a);
    if (shadow1.exists(a)) return shadow1[a];
    return init_val(a);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (b1.p0_gnt === 1'b1) begin
        if (b1.p0_we) shadow1[int'(b1.p0_addr[7:0])] = b1.p0_wdata;
        else q0.push_back('{sh_rd(int'(b1.p0_addr[7:0])), cyc + 2});
      end
      if (b1.p1_gnt === 1'b1) begin
        if (b1.p1_we) shadow1[int'(b1.p1_addr[7:0])] = b1.p1_wdata;
        else q1.push_back('{sh_rd(int'(b1.p1_addr[7:0])), cyc + 2});
      end
      if (b3.p0_gnt === 1'b1 && !b3.p0_we)
        q3.push_back('{init_val(int'(b3.p0_addr[7:0])), cyc + 4});
    end
  end

  // a reset edge discards every in-flight read
  always @(posedge clk) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      q3.delete();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.p0_rvalid === 1'b1) begin
      if (q0.size() == 0) begin
        nchk++;
        $display("FAIL p0_spurious_rvalid: got rvalid=1 data 0x%0h expected no pending read", b1.p0_rdata);
      end else begin
        e = q0.pop_front();
        check("p0_rdata", b1.p0_rdata, e.data);
        check("p0_rvalid_cycle", cyc, e.due);
      end
    end
    if (b1.p1_rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        nchk++;
        $display("FAIL p1_spurious_rvalid: got rvalid=1 data 0x%0h expected no pending read", b1.p1_rdata);
      end else begin
        e = q1.pop_front();
        check("p1_rdata", b1.p1_rdata, e.data);
        check("p1_rvalid_cycle", cyc, e.due);
      end
    end
    if (b3.p0_rvalid === 1'b1) begin
      if (q3.size() == 0) begin
        nchk++;
        $display("FAIL lat3_spurious_rvalid: got rvalid=1 data 0x%0h expected no pending read", b3.p0_rdata);
      end else begin
        e = q3.pop_front();
        check("lat3_rdata", b3.p0_rdata, e.data);
        check("lat3_rvalid_cycle", cyc, e.due);
      end
    end
    if (b3.p1_rvalid === 1'b1) begin
      nchk++;
      $display("FAIL lat3_p1_rvalid: got 1 expected 0");
    end
  end

  task automatic drive1(input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    b1.p0_req = r0; b1.p0_we = w0; b1.p0_addr = a0; b1.p0_wdata = d0;
    b1.p1_req = r1; b1.p1_we = w1; b1.p1_addr = a1; b1.p1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle1(input int n);
    repeat (n) drive1(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
  endtask

  task automatic drive3(input logic r0, input logic [15:0] a0);
    @(posedge clk);
    #1;
    b3.p0_req = r0; b3.p0_addr = a0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    reset = 1'b0;
    b1.p0_req = 1'b0; b1.p1_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic r0, w0; logic [15:0] a0; logic [31:0] d0;
    logic r1, w1; logic [15:0] a1; logic [31:0] d1;
    logic g0, g1, we; logic [15:0] ma; logic [31:0] md;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int cnt;
    logic [15:0] na0, na1;

    tbl[0] = '{1,0,16'h01,32'h0,          1,0,16'h02,32'h0,          1,0,0,16'h01,32'h0};
    tbl[1] = '{1,0,16'h03,32'h0,          1,0,16'h02,32'h0,          0,1,0,16'h02,32'h0};
    tbl[2] = '{1,0,16'h03,32'h0,          0,0,16'h00,32'h0,          1,0,0,16'h03,32'h0};
    tbl[3] = '{0,0,16'h00,32'h0,          1,1,16'h20,32'hDEAD0001,   0,1,1,16'h20,32'hDEAD0001};
    tbl[4] = '{0,0,16'h00,32'h0,          1,0,16'h20,32'h0,          0,1,0,16'h20,32'h0};
    tbl[5] = '{0,0,16'h00,32'h0,          0,0,16'h00,32'h0,          0,0,0,16'h00,32'h0};
    tbl[6] = '{1,1,16'h21,32'h5A5A0021,   1,0,16'h05,32'h0,          1,0,1,16'h21,32'h5A5A0021};
    tbl[7] = '{1,0,16'h21,32'h0,          1,0,16'h05,32'h0,          0,1,0,16'h05,32'h0};
    tbl[8] = '{1,0,16'h21,32'h0,          0,0,16'h00,32'h0,          1,0,0,16'h21,32'h0};
    tbl[9] = '{0,0,16'h00,32'h0,          0,0,16'h00,32'h0,          0,0,0,16'h00,32'h0};

    b3.p0_req = 0; b3.p0_we = 0; b3.p0_addr = 0; b3.p0_wdata = 0;
    b3.p1_req = 0; b3.p1_we = 0; b3.p1_addr = 0; b3.p1_wdata = 0;
    b1.p0_req = 1; b1.p0_we = 0; b1.p0_addr = 16'h5; b1.p0_wdata = 0;
    b1.p1_req = 1; b1.p1_we = 0; b1.p1_addr = 16'h6; b1.p1_wdata = 0;

    // reset held with both ports requesting
    repeat (3) begin
      @(negedge clk);
      check("rst_p0_gnt", b1.p0_gnt, 0);
      check("rst_p1_gnt", b1.p1_gnt, 0);
      check("rst_mem_we", b1.mem_we, 0);
      check("rst_p0_rvalid", b1.p0_rvalid, 0);
      check("rst_p1_rvalid", b1.p1_rvalid, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_p0_gnt", b1.p0_gnt, 1);
    check("rel_p1_gnt", b1.p1_gnt, 0);
    drive1(0, 0, 16'h0, 32'h0, 1, 0, 16'h6, 32'h0);
    check("rel_p1_gnt_next", b1.p1_gnt, 1);
    idle1(4);

    // lone read, returned two edges after the grant
    drive1(1, 0, 16'h5, 32'h0, 0, 0, 16'h0, 32'h0);
    check("lone_p0_gnt", b1.p0_gnt, 1);
    check("lone_mem_addr", b1.mem_addr, 32'h5);
    idle1(1);
    check("lone_rvalid_early", b1.p0_rvalid, 0);
    idle1(1);
    check("lone_p0_rvalid", b1.p0_rvalid, 1);
    check("lone_p0_rdata", b1.p0_rdata, 32'h12340002);
    check("lone_p1_rvalid", b1.p1_rvalid, 0);
    idle1(3);

    // contention: grants must alternate starting at port 0
    reset_pulse();
    na0 = 16'h40;
    na1 = 16'h80;
    for (int i = 0; i < 6; i++) begin
      drive1(1, 0, na0, 32'h0, 1, 0, na1, 32'h0);
      check($sformatf("cont%0d_p0_gnt", i), b1.p0_gnt, (i % 2 == 0));
      check($sformatf("cont%0d_p1_gnt", i), b1.p1_gnt, (i % 2 == 1));
      if (i % 2 == 0) na0 = na0 + 16'h1;
      else na1 = na1 + 16'h1;
    end
    idle1(4);

    // write then read on port 1
    drive1(0, 0, 16'h0, 32'h0, 1, 1, 16'h10, 32'hFFFFFFFC);
    check("raw_wr_gnt", b1.p1_gnt, 1);
    check("raw_wr_we", b1.mem_we, 1);
    drive1(0, 0, 16'h0, 32'h0, 1, 0, 16'h10, 32'h0);
    check("raw_rd_gnt", b1.p1_gnt, 1);
    check("raw_rd_we", b1.mem_we, 0);
    idle1(1);
    check("raw_no_wr_rvalid", b1.p1_rvalid, 0);
    idle1(1);
    check("raw_p1_rvalid", b1.p1_rvalid, 1);
    check("raw_p1_rdata", b1.p1_rdata, 32'hFFFFFFFC);
    idle1(3);

    // reset while a read is in flight
    drive1(1, 0, 16'h7, 32'h0, 0, 0, 16'h0, 32'h0);
    check("mid_p0_gnt", b1.p0_gnt, 1);
    reset_pulse();
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (b1.p0_rvalid === 1'b1) cnt++;
    end
    check("mid_no_rvalid", cnt, 0);
    drive1(1, 0, 16'h9, 32'h0, 1, 0, 16'hA, 32'h0);
    check("mid_rr_p0_gnt", b1.p0_gnt, 1);
    check("mid_rr_p1_gnt", b1.p1_gnt, 0);
    drive1(0, 0, 16'h0, 32'h0, 1, 0, 16'hA, 32'h0);
    check("mid_p1_gnt", b1.p1_gnt, 1);
    idle1(4);

    // grant table from a fresh round-robin state
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      drive1(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      check($sformatf("vec%0d_p0_gnt", i), b1.p0_gnt, tbl[i].g0);
      check($sformatf("vec%0d_p1_gnt", i), b1.p1_gnt, tbl[i].g1);
      check($sformatf("vec%0d_mem_we", i), b1.mem_we, tbl[i].we);
      check($sformatf("vec%0d_mem_addr", i), b1.mem_addr, tbl[i].ma);
      check($sformatf("vec%0d_mem_wdata", i), b1.mem_wdata, tbl[i].md);
    end
    idle1(4);

    // RD_LAT=3 instance: four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive3(1, 16'h8 + 16'(i));
      check($sformatf("lat3_gnt%0d", i), b3.p0_gnt, 1);
    end
    drive3(0, 16'h0);
    repeat (8) @(negedge clk);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
